// File: rtl/k2_out_uart_tx.sv
// K2 output stage: captures R0 loads into a small FIFO and serialises them as 8N1 frames.
// The core cannot be stalled, so pushes into a full FIFO are dropped and flagged sticky.
module k2_out_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_out_we,
  input  logic [7:0]                   i_out_data,
  output logic                         o_tx,
  output logic                         o_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
  output logic                         o_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  state_t        w_state_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_tx_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_empty;
  logic          w_full;
  logic          w_timer_last;
  logic [7:0]    w_head;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == COUNT_FULL);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_timer_last = (r_timer == TIMER_LAST);

  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
  assign w_push = i_out_we & (~w_full | w_pop);
  assign w_drop = i_out_we & w_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_out_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state logic; emptiness comes from the registered count, so a same-cycle push is not seen.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
          w_timer_nxt = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_timer_last) begin
          w_timer_nxt = '0;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_DATA: begin
        if (w_timer_last) begin
          w_timer_nxt = '0;
          if (r_idx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
            w_idx_nxt   = r_idx + 3'd1;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_STOP: begin
        if (w_timer_last) begin
          w_timer_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_timer_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_tx         = r_tx;
  assign o_tx_busy    = (r_state != S_IDLE);
  assign o_fifo_count = r_count;
  assign o_overflow   = r_overflow;

endmodule
